branch_resolve_unit: RTL and testbench

//   Parametrised successor to the single-AND branch decision. Resolves all MIPS

---
 rtl/branch_resolve_unit.sv | 112 +++++++++++
 tb/tb_branch_resolve_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves MIPS conditional branches in EX and trains a PC-indexed
// table of saturating counters for IF prediction. Define BRU_STATS_EN to build the stats counters.
module branch_resolve_unit #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned CNT_INIT  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_br_type,
  input  logic            ex_zero,
  input  logic            ex_neg,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_pred_taken,
  output logic            pc_src,
  output logic            mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_type_e;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [CNT_W-1:0] cnt_q [BHT_DEPTH];
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_d;
  logic             cond;
  logic             br_known;
  logic             upd_en;
  logic             unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  // Reads the registered array directly: a same-index update shows up next cycle.
  assign if_pred_taken = cnt_q[if_idx][CNT_W-1];

  always_comb begin
    cond     = 1'b0;
    br_known = 1'b1;
    case (br_type_e'(ex_br_type))
      BR_BEQ:  cond = ex_zero;
      BR_BNE:  cond = !ex_zero;
      BR_BLEZ: cond = ex_neg | ex_zero;
      BR_BGTZ: cond = !ex_neg & !ex_zero;
      BR_BLTZ: cond = ex_neg;
      BR_BGEZ: cond = !ex_neg;
      default: br_known = 1'b0;
    endcase
  end

  assign pc_src     = ex_valid & ex_branch & cond;
  assign mispredict = ex_valid & (pc_src != ex_pred_taken);
  assign upd_en     = ex_valid & ex_branch & br_known;

  always_comb begin
    cnt_cur = cnt_q[ex_idx];
    cnt_d   = cnt_cur;
    if (pc_src) begin
      if (cnt_cur != '1) cnt_d = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0) cnt_d = cnt_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= CNT_W'(CNT_INIT);
    end else if (upd_en) begin
      cnt_q[ex_idx] <= cnt_d;
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (upd_en && stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict && stat_mp_q != '1) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expectations, a negedge monitor checks them.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_branch, ex_zero, ex_neg, ex_pred_taken;
  logic [2:0]  ex_br_type;
  logic [31:0] ex_pc;
  logic        pc_src, mispredict;
  logic [31:0] stat_branches, stat_mispredicts;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(32), .BHT_DEPTH(64), .CNT_W(2), .CNT_INIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_br_type(ex_br_type),
    .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .pc_src(pc_src), .mispredict(mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    string       tag;
    logic        pred;
    logic        src;
    logic        mis;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int   m_cnt [64];
  int   m_br = 0;
  int   m_mp = 0;

  // Hand-derived decode: bit0 (zero=0,neg=0), bit1 (zero=0,neg=1), bit2 (zero=1,neg=0)
  logic [2:0] dec_tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.tag, ".pred"}, {31'd0, if_pred_taken}, {31'd0, e.pred});
        chk({e.tag, ".pc_src"}, {31'd0, pc_src}, {31'd0, e.src});
        chk({e.tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.mis});
        chk({e.tag, ".stat_br"}, stat_branches, e.sb);
        chk({e.tag, ".stat_mp"}, stat_mispredicts, e.sm);
      end
    end
  end

  function automatic exp_t mk_exp(input string tag, input logic [31:0] ipc,
                                  input logic src, input logic mis);
    exp_t e;
    e.tag  = tag;
    e.pred = (m_cnt[ipc[7:2]] >= 2);
    e.src  = src;
    e.mis  = mis;
`ifdef BRU_STATS_EN
    e.sb = m_br;
    e.sm = m_mp;
`else
    e.sb = 32'd0;
    e.sm = 32'd0;
`endif
    return e;
  endfunction

  task automatic step(input string tag, input logic [31:0] ipc, input logic v, input logic b,
                      input logic [2:0] t, input logic z, input logic n,
                      input logic [31:0] epc, input logic pt, input logic exp_src);
    logic mis;
    @(posedge clk); #1;
    if_pc = ipc; ex_valid = v; ex_branch = b; ex_br_type = t;
    ex_zero = z; ex_neg = n; ex_pc = epc; ex_pred_taken = pt;
    mis = v & (exp_src != pt);
    sbq.push_back(mk_exp(tag, ipc, exp_src, mis));
    if (v && b && t < 3'd6) begin
      m_br++;
      if (exp_src) begin
        if (m_cnt[epc[7:2]] < 3) m_cnt[epc[7:2]]++;
      end else begin
        if (m_cnt[epc[7:2]] > 0) m_cnt[epc[7:2]]--;
      end
    end
    if (mis) m_mp++;
  endtask

  task automatic idle(input string tag, input logic [31:0] ipc);
    step(tag, ipc, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    m_br = 0;
    m_mp = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    dec_tbl[0] = 3'b100;  // BEQ
    dec_tbl[1] = 3'b011;  // BNE
    dec_tbl[2] = 3'b110;  // BLEZ
    dec_tbl[3] = 3'b001;  // BGTZ
    dec_tbl[4] = 3'b010;  // BLTZ
    dec_tbl[5] = 3'b101;  // BGEZ
    dec_tbl[6] = 3'b000;
    dec_tbl[7] = 3'b000;
    model_reset();
    rst_n = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_branch = 1'b0; ex_br_type = '0;
    ex_zero = 1'b0; ex_neg = 1'b0; ex_pc = '0; ex_pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 64; i++) idle("reset_sweep", 32'(i * 4));

    step("beq_taken", 32'h40, 1, 1, 3'd0, 1, 0, 32'h40, 0, 1'b1);
    idle("beq_pred_next", 32'h40);

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 3; k++) begin
        logic [2:0] row;
        row = dec_tbl[t];
        step($sformatf("decode_t%0d_k%0d", t, k), 32'(32'hC0 + t * 4), 1, 1, 3'(t),
             (k == 2), (k == 1), 32'(32'hC0 + t * 4), 0, row[k]);
      end
    end
    step("resv_then_taken", 32'hD8, 1, 1, 3'd0, 1, 0, 32'hD8, 0, 1'b1);
    idle("resv_pred", 32'hD8);
    idle("resv7_pred", 32'hDC);

    for (int i = 0; i < 4; i++) step("sat_taken", 32'h80, 1, 1, 3'd0, 1, 0, 32'h80, 0, 1'b1);
    for (int i = 0; i < 4; i++) step("sat_nt", 32'h80, 1, 1, 3'd0, 0, 0, 32'h80, 1, 1'b0);
    idle("sat_floor", 32'h80);

    step("collide_same", 32'h0, 1, 1, 3'd0, 1, 0, 32'h100, 0, 1'b1);
    idle("collide_next", 32'h0);

    step("nonbranch_pt", 32'h40, 1, 0, 3'd0, 1, 0, 32'h40, 1, 1'b0);
    idle("nonbranch_noupd", 32'h40);

    // Reset pulse lands between edges; the monitor samples while rst_n is low.
    @(posedge clk); #1;
    if_pc = 32'h40; ex_valid = 1'b0; ex_branch = 1'b0; ex_pred_taken = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    sbq.push_back(mk_exp("async_reset", 32'h40, 1'b0, 1'b0));
    @(negedge clk); #1 rst_n = 1'b1;
    idle("post_reset_80", 32'h80);
    idle("post_reset_0", 32'h0);
    step("post_reset_train", 32'h40, 1, 1, 3'd1, 0, 0, 32'h40, 0, 1'b1);
    idle("post_reset_pred", 32'h40);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
